// File: rtl/keypad_scan_fsm.sv
// 4x4 matrix keypad scanner: rotates a one-hot column drive, debounces the first
// single-row press, latches the column/row pair and locks out other keys until release.
module keypad_scan_fsm #(
    parameter int SETTLE_CYCLES   = 4,
    parameter int DEBOUNCE_CYCLES = 60000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rowIn,
    output logic [3:0] colOut,
    output logic [3:0] storedCol,
    output logic [3:0] storedRow,
    output logic       newPress,
    output logic       keyHeld
);

    localparam int MAX_CYCLES = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES : DEBOUNCE_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD
    } state_t;

    state_t           state, state_next;
    logic [3:0]       row_meta, rowSync;
    logic [3:0]       candRow, cand_next;
    logic [3:0]       col_next, stored_col_next, stored_row_next;
    logic [CNT_W-1:0] settleCnt, settle_next;
    logic [CNT_W-1:0] debCnt, deb_next;
    logic             press_next, held_next;
    logic             row_valid;
    logic [3:0]       col_rot;

    // Exactly one row asserted; zero or several rows are rejected.
    assign row_valid = (rowSync != '0) && ((rowSync & (rowSync - 4'd1)) == '0);
    assign col_rot   = {colOut[2:0], colOut[3]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_meta  <= '0;
            rowSync   <= '0;
            state     <= SCAN;
            colOut    <= 4'b0001;
            settleCnt <= '0;
            debCnt    <= '0;
            candRow   <= '0;
            storedCol <= '0;
            storedRow <= '0;
            newPress  <= 1'b0;
            keyHeld   <= 1'b0;
        end else begin
            row_meta  <= rowIn;
            rowSync   <= row_meta;
            state     <= state_next;
            colOut    <= col_next;
            settleCnt <= settle_next;
            debCnt    <= deb_next;
            candRow   <= cand_next;
            storedCol <= stored_col_next;
            storedRow <= stored_row_next;
            newPress  <= press_next;
            keyHeld   <= held_next;
        end
    end

    always_comb begin
        state_next      = state;
        col_next        = colOut;
        settle_next     = settleCnt;
        deb_next        = debCnt;
        cand_next       = candRow;
        stored_col_next = storedCol;
        stored_row_next = storedRow;
        press_next      = 1'b0;
        held_next       = keyHeld;

        unique case (state)
            SCAN: begin
                if (settleCnt == SETTLE_LAST) begin
                    settle_next = '0;
                    if (row_valid) begin
                        cand_next  = rowSync;
                        deb_next   = '0;
                        state_next = DEBOUNCE;
                    end else begin
                        col_next = col_rot;
                    end
                end else begin
                    settle_next = settleCnt + 1'b1;
                end
            end

            DEBOUNCE: begin
                if (rowSync == candRow) begin
                    if (debCnt == DEB_LAST) begin
                        stored_col_next = colOut;
                        stored_row_next = candRow;
                        press_next      = 1'b1;
                        held_next       = 1'b1;
                        deb_next        = '0;
                        state_next      = HELD;
                    end else begin
                        deb_next = debCnt + 1'b1;
                    end
                end else begin
                    col_next    = col_rot;
                    settle_next = '0;
                    deb_next    = '0;
                    state_next  = SCAN;
                end
            end

            HELD: begin
                // Only the held column is driven, so any nonzero row restarts the release count.
                if (rowSync == '0) begin
                    if (debCnt == DEB_LAST) begin
                        held_next   = 1'b0;
                        col_next    = col_rot;
                        settle_next = '0;
                        deb_next    = '0;
                        state_next  = SCAN;
                    end else begin
                        deb_next = debCnt + 1'b1;
                    end
                end else begin
                    deb_next = '0;
                end
            end

            default: begin
                state_next = SCAN;
            end
        endcase
    end

endmodule

// File: tb/tb_keypad_scan_fsm.sv
// Directed bench for keypad_scan_fsm with a behavioural keypad matrix and a
// scoreboard of expected column/row pairs popped on every newPress pulse.
module tb_keypad_scan_fsm;

    logic       clk;
    logic       reset;
    logic [3:0] rowIn;
    logic [3:0] colOut;
    logic [3:0] storedCol;
    logic [3:0] storedRow;
    logic       newPress;
    logic       keyHeld;

    typedef struct packed {
        logic [3:0] col;
        logic [3:0] row;
    } pair_t;

    pair_t      exp_q[$];
    pair_t      mon_pair;
    logic [3:0] keys [4];
    int         checks = 0;
    int         errors = 0;
    int         press_count = 0;
    logic       prev_np = 1'b0;

    keypad_scan_fsm #(
        .SETTLE_CYCLES(4),
        .DEBOUNCE_CYCLES(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rowIn(rowIn),
        .colOut(colOut),
        .storedCol(storedCol),
        .storedRow(storedRow),
        .newPress(newPress),
        .keyHeld(keyHeld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A row line is high only when its key is pressed in the driven column.
    always_comb begin
        rowIn = '0;
        for (int c = 0; c < 4; c++)
            if (colOut[c]) rowIn = rowIn | keys[c];
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_press(input int max, output int cycles, output logic seen);
        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles < max) begin
            @(posedge clk);
            #1;
            cycles++;
            if (newPress === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic wait_release(input int max, output int cycles, output logic seen);
        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles < max) begin
            @(posedge clk);
            #1;
            cycles++;
            if (keyHeld === 1'b0) seen = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (newPress === 1'b1) begin
                press_count++;
                check("np_not_twice", 16'(prev_np), 16'd0);
                check("press_pending", 16'(exp_q.size()), 16'd1);
                if (exp_q.size() > 0) begin
                    mon_pair = exp_q.pop_front();
                    check("stored_pair", {8'h00, storedCol, storedRow}, {8'h00, mon_pair.col, mon_pair.row});
                end
            end
            prev_np = newPress;
        end else begin
            prev_np = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int         cyc;
        logic       seen;
        int         pc_before;
        logic [3:0] col_exp;

        reset = 1'b1;
        for (int c = 0; c < 4; c++) keys[c] = '0;
        #12;
        check("rst_col", 16'(colOut), 16'h1);
        check("rst_scol", 16'(storedCol), 16'h0);
        check("rst_srow", 16'(storedRow), 16'h0);
        check("rst_np", 16'(newPress), 16'h0);
        check("rst_kh", 16'(keyHeld), 16'h0);
        #10;
        reset = 1'b0;

        // Idle scan: four cycles per column.
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            col_exp = 4'b0001 << ((k / 4) % 4);
            check("idle_col", 16'(colOut), 16'(col_exp));
            check("idle_np", 16'(newPress), 16'h0);
        end
        check("idle_scol", 16'(storedCol), 16'h0);
        check("idle_srow", 16'(storedRow), 16'h0);

        // Clean press of row 0010 in column 0100.
        exp_q.push_back(pair_t'{col: 4'b0100, row: 4'b0010});
        keys[2] = 4'b0010;
        wait_press(30, cyc, seen);
        check("press1_seen", 16'(seen), 16'h1);
        check("press1_latency", 16'(cyc), 16'd12);
        check("press1_scol", 16'(storedCol), 16'h4);
        check("press1_srow", 16'(storedRow), 16'h2);
        check("press1_kh", 16'(keyHeld), 16'h1);
        check("press1_col", 16'(colOut), 16'h4);

        // Hold, and press a key in column 1000 that must stay invisible.
        for (int i = 1; i <= 18; i++) begin
            @(posedge clk);
            #1;
            if (i == 8) keys[3] = 4'b0001;
            check("hold_col", 16'(colOut), 16'h4);
            check("hold_kh", 16'(keyHeld), 16'h1);
            check("hold_np", 16'(newPress), 16'h0);
        end

        exp_q.push_back(pair_t'{col: 4'b1000, row: 4'b0001});
        keys[2] = '0;
        wait_release(40, cyc, seen);
        check("rel1_seen", 16'(seen), 16'h1);
        check("rel1_latency", 16'(cyc), 16'd10);
        check("rel1_col", 16'(colOut), 16'h8);
        check("rel1_scol", 16'(storedCol), 16'h4);
        check("rel1_srow", 16'(storedRow), 16'h2);

        // The column-1000 key is only accepted after the release plus a fresh debounce.
        wait_press(30, cyc, seen);
        check("press2_seen", 16'(seen), 16'h1);
        check("press2_latency", 16'(cyc), 16'd12);
        check("press2_scol", 16'(storedCol), 16'h8);
        check("press2_srow", 16'(storedRow), 16'h1);

        keys[3] = '0;
        wait_release(40, cyc, seen);
        check("rel2_latency", 16'(cyc), 16'd10);
        check("rel2_col", 16'(colOut), 16'h1);

        // Two rows in one column: never valid, scanning keeps rotating.
        pc_before = press_count;
        keys[0] = 4'b0011;
        repeat (40) @(posedge clk);
        #1;
        check("multi_col", 16'(colOut), 16'h4);
        check("multi_kh", 16'(keyHeld), 16'h0);
        check("multi_presses", 16'(press_count), 16'(pc_before));
        check("multi_scol", 16'(storedCol), 16'h8);
        check("multi_srow", 16'(storedRow), 16'h1);
        keys[0] = '0;

        // Bouncing contact: one low cycle every five.
        pc_before = press_count;
        for (int i = 0; i < 60; i++) begin
            keys[0] = (i % 5 == 4) ? 4'b0000 : 4'b0001;
            @(posedge clk);
            #1;
        end
        check("bounce_presses", 16'(press_count), 16'(pc_before));
        check("bounce_scol", 16'(storedCol), 16'h8);
        check("bounce_srow", 16'(storedRow), 16'h1);
        check("bounce_kh", 16'(keyHeld), 16'h0);

        exp_q.push_back(pair_t'{col: 4'b0001, row: 4'b0001});
        keys[0] = 4'b0001;
        wait_press(60, cyc, seen);
        check("press3_seen", 16'(seen), 16'h1);
        check("press3_scol", 16'(storedCol), 16'h1);
        check("press3_srow", 16'(storedRow), 16'h1);
        check("press3_kh", 16'(keyHeld), 16'h1);

        keys[0] = '0;
        wait_release(40, cyc, seen);
        check("rel3_seen", 16'(seen), 16'h1);

        // Reset in the middle of a hold on column 0010.
        exp_q.push_back(pair_t'{col: 4'b0010, row: 4'b1000});
        keys[1] = 4'b1000;
        wait_press(60, cyc, seen);
        check("press4_seen", 16'(seen), 16'h1);
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_kh", 16'(keyHeld), 16'h1);
        check("pre_rst_col", 16'(colOut), 16'h2);
        #3;
        reset = 1'b1;
        #1;
        check("async_rst_col", 16'(colOut), 16'h1);
        check("async_rst_scol", 16'(storedCol), 16'h0);
        check("async_rst_srow", 16'(storedRow), 16'h0);
        check("async_rst_np", 16'(newPress), 16'h0);
        check("async_rst_kh", 16'(keyHeld), 16'h0);
        keys[1] = '0;
        repeat (2) @(posedge clk);
        #2;
        check("in_rst_col", 16'(colOut), 16'h1);
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            col_exp = 4'b0001 << ((k / 4) % 4);
            check("post_rst_col", 16'(colOut), 16'(col_exp));
            check("post_rst_kh", 16'(keyHeld), 16'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/keypad_scan_fsm.md
# keypad_scan_fsm

Scans a 4x4 matrix keypad by driving one column at a time and sampling the four row lines. It debounces the first valid press and latches the one-hot column/row pair into registers that feed the keypad decoder directly. It also emits a single-cycle new-press pulse for the downstream digit-history and display logic. Each physical press is reported exactly once, and other keys are ignored while a key is held.

## Interface
- SETTLE_CYCLES, 4: cycles a column is driven before rows are sampled; must be >= 3 to cover synchronizer latency.
- DEBOUNCE_CYCLES, 60000: consecutive stable cycles required to accept a press or a release; must be >= 1.
- clk  input  1  system clock (single clock domain).
- reset  input  1  asynchronous, active-high reset.
- rowIn  input  4  raw row lines, active-high, asynchronous to clk.
- colOut  output  4  one-hot active-high column drive to keypad.
- storedCol  output  4  one-hot column of the last accepted key; to decoder.
- storedRow  output  4  one-hot row of the last accepted key; to decoder.
- newPress  output  1  one-cycle pulse when a debounced press is accepted.
- keyHeld  output  1  high from press acceptance until release acceptance.

## Operation
- rowIn passes through a 2-flop synchronizer, giving rowSync. All decisions use rowSync only.
- A row sample is valid when it has exactly one bit set. Zero bits or multiple bits set count as invalid.
- Column rotation is 0001 -> 0010 -> 0100 -> 1000 -> 0001.
- settleCnt and debCnt are unsigned counters of width $clog2(max(SETTLE_CYCLES, DEBOUNCE_CYCLES)+1).

State SCAN:
- colOut holds the current column and settleCnt increments each cycle.
- When settleCnt reaches SETTLE_CYCLES-1, rowSync is sampled that cycle and settleCnt clears.
- Valid sample: capture the row in candRow and go to DEBOUNCE with debCnt=0.
- Invalid sample: advance to the next column and stay in SCAN.

State DEBOUNCE:
- colOut is held.
- If rowSync == candRow, debCnt increments.
- If rowSync differs (zero, another bit, or multiple bits), advance the column, clear the counters and return to SCAN.
- When debCnt reaches DEBOUNCE_CYCLES-1 with rowSync == candRow:
  - storedCol <= colOut and storedRow <= candRow;
  - newPress = 1 for one cycle;
  - keyHeld <= 1;
  - go to HELD.

State HELD:
- colOut is held and storedCol/storedRow do not change.
- debCnt counts consecutive cycles with rowSync == 0. Any nonzero rowSync clears debCnt.
- Keys in other columns cannot be seen in this state and are ignored. Extra keys in the same column keep debCnt at 0.
- When debCnt reaches DEBOUNCE_CYCLES-1 with rowSync == 0:
  - keyHeld <= 0;
  - advance the column;
  - go to SCAN.

Outputs:
- storedCol/storedRow retain the last accepted key indefinitely; they are only overwritten on the next acceptance.
- newPress never asserts in two consecutive cycles.
- Between any two newPress pulses there is at least one keyHeld 1->0 transition.

## Timing
Reset (asynchronous, takes effect immediately, including mid-debounce or mid-hold):
- state = SCAN, colOut = 0001;
- storedCol = 0000, storedRow = 0000 (decoder then outputs 0);
- newPress = 0, keyHeld = 0;
- settleCnt = debCnt = 0, synchronizer flops = 0.

After reset release:
- The first sample of column 0001 occurs SETTLE_CYCLES cycles after the first active clock edge.
- Each column dwell with no valid sample is SETTLE_CYCLES cycles, so a full idle scan is 4*SETTLE_CYCLES cycles.

Press latency:
- From the sampling edge to the newPress pulse is DEBOUNCE_CYCLES cycles.
- From the rowIn edge, add the 2 synchronizer cycles plus the remaining column dwell.
- storedCol/storedRow update on the same edge that raises newPress, and keyHeld rises on that edge too.

Release latency: keyHeld falls DEBOUNCE_CYCLES cycles after rowSync first goes to zero and stays there.

Mid-operation edge cases:
- A bounce during DEBOUNCE restarts scanning at the next column; no partial acceptance occurs.
- A bounce during HELD only restarts the release count.

## Test plan
All scenarios use SETTLE_CYCLES=4 and DEBOUNCE_CYCLES=8.
- Idle scan: rowIn=0 for 40 cycles after reset -> colOut cycles 0001, 0010, 0100, 1000 with 4 cycles each; newPress=0; storedCol/storedRow=0000.
- Clean press: rowIn=0010 while colOut=0100, held 30 cycles -> exactly one newPress; storedCol=0100, storedRow=0010 (decoder gives 6); keyHeld=1; colOut frozen at 0100.
- Release:
  - Stimulus: after the clean press, set rowIn=0.
  - Required: keyHeld falls exactly 8 cycles after rowSync goes to 0, and scanning resumes at colOut=1000.
  - Required: storedCol/storedRow stay 0100/0010.
- Bounce:
  - Stimulus: rowIn=0001 on column 0001, toggled to 0 for 1 cycle every 5 cycles.
  - Required: no newPress and no change to storedCol/storedRow.
  - Stimulus then changes to a stable 0001 -> required: newPress, storedRow=0001.
- Multi-key and held-key lockout:
  - Stimulus: rowIn=0011 -> required: treated as invalid and never accepted.
  - Stimulus: while key (0010,0100) is held, also press a key in column 1000 -> required: no second newPress until release plus a new debounced press.
- Reset mid-hold: assert reset in HELD -> all outputs return to reset values immediately, asynchronously; after release, scanning starts at colOut=0001.
